// File: rtl/rv_iommu_axi4_burst_splitter_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_iommu_axi4_burst_splitter_if
// Description : Signal bundle between an AXI4 address-channel source and the
//               burst splitter, and between the splitter and the IOMMU
//               translation request path.
//                 req_*             : incoming AxVALID/AxREADY/AxADDR/...
//                 out_*             : outgoing legal (sub-)bursts
//                 bound_violation_* : rejected-request pulse and its ID
//               Modport 'slave' is the splitter's view; modport 'master' is
//               the view of the agent that drives requests and accepts
//               sub-bursts.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_iommu_axi4_burst_splitter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 4
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [1:0]            req_burst_i;
    logic [7:0]            req_len_i;
    logic [2:0]            req_size_i;
    logic [ID_WIDTH-1:0]   req_id_i;

    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [ADDR_WIDTH-1:0] out_addr_o;
    logic [7:0]            out_len_o;
    logic [2:0]            out_size_o;
    logic [1:0]            out_burst_o;
    logic [ID_WIDTH-1:0]   out_id_o;
    logic                  out_last_o;

    logic                  bound_violation_o;
    logic [ID_WIDTH-1:0]   bound_violation_id_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_burst_i, req_len_i, req_size_i,
               req_id_i, out_ready_i,
        output req_ready_o, out_valid_o, out_addr_o, out_len_o, out_size_o,
               out_burst_o, out_id_o, out_last_o, bound_violation_o,
               bound_violation_id_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_burst_i, req_len_i, req_size_i,
               req_id_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_addr_o, out_len_o, out_size_o,
               out_burst_o, out_id_o, out_last_o, bound_violation_o,
               bound_violation_id_o
    );
endinterface
`default_nettype wire

// File: rtl/rv_iommu_axi4_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module      : rv_iommu_axi4_burst_splitter
// Description : Registered AXI4 address-channel boundary checker/splitter.
//               Legal, contained bursts are forwarded unchanged. INCR bursts
//               crossing a 2^BOUND_LOG2-byte boundary are cut into legal
//               sub-bursts (or rejected when SPLIT_EN=0). Illegal FIXED/WRAP
//               bursts and illegal encodings are consumed and reported with a
//               one-cycle bound_violation pulse carrying the request ID.
// Ports       : clk_i  - clock
//               rst_i  - asynchronous active-high reset
//               bus    - request / sub-burst / violation bundle (slave view)
// Revision    : 1.0 - initial release
// ============================================================================
module rv_iommu_axi4_burst_splitter #(
    parameter int ADDR_WIDTH = 64,
    parameter int BOUND_LOG2 = 12,
    parameter int DATA_LOG2  = 3,
    parameter int ID_WIDTH   = 4,
    parameter bit SPLIT_EN   = 1'b1
) (
    input wire clk_i,
    input wire rst_i,
    rv_iommu_axi4_burst_splitter_if.slave bus
);

    // Wide enough for 2^BOUND_LOG2 plus a 256-beat x 128-byte product.
    localparam int c_W = BOUND_LOG2 + 10;

    localparam logic [c_W-1:0]        c_BOUND    = c_W'(1) << BOUND_LOG2;
    localparam logic [ADDR_WIDTH-1:0] c_BOUND_A  = ADDR_WIDTH'(1) << BOUND_LOG2;
    localparam logic [ADDR_WIDTH-1:0] c_OFF_MASK = c_BOUND_A - ADDR_WIDTH'(1);

    localparam logic [1:0] c_BURST_FIXED = 2'b00;
    localparam logic [1:0] c_BURST_INCR  = 2'b01;
    localparam logic [1:0] c_BURST_WRAP  = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [7:0]            r_out_len;
    logic [2:0]            r_out_size;
    logic [1:0]            r_out_burst;
    logic [ID_WIDTH-1:0]   r_out_id;
    logic                  r_out_last;
    logic [8:0]            r_rem;        // beats still to issue after the current sub-burst
    logic [ADDR_WIDTH-1:0] r_next_addr;  // boundary-aligned start of the next sub-burst
    logic                  r_viol;
    logic [ID_WIDTH-1:0]   r_viol_id;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_out_addr_nxt;
    logic [7:0]            w_out_len_nxt;
    logic [2:0]            w_out_size_nxt;
    logic [1:0]            w_out_burst_nxt;
    logic [ID_WIDTH-1:0]   w_out_id_nxt;
    logic                  w_out_last_nxt;
    logic [8:0]            w_rem_nxt;
    logic [ADDR_WIDTH-1:0] w_next_addr_nxt;
    logic                  w_viol_nxt;
    logic [ID_WIDTH-1:0]   w_viol_id_nxt;

    // ------------------------------------------------------------------
    // Request classification arithmetic
    // ------------------------------------------------------------------
    logic [c_W-1:0] w_off;
    logic [c_W-1:0] w_bpb;        // bytes per beat
    logic [c_W-1:0] w_beats;
    logic [c_W-1:0] w_room;       // beats that fit before the next boundary
    logic [c_W-1:0] w_total;      // bytes in the whole burst
    logic [c_W-1:0] w_wrap_off;   // wrap boundary offset inside the region
    logic           w_size_ok;
    logic           w_aligned;
    logic           w_len_wrap_ok;
    logic           w_legal;
    logic           w_split;
    logic           w_violation;

    always_comb begin
        w_off         = c_W'(bus.req_addr_i[BOUND_LOG2-1:0]);
        w_bpb         = c_W'(1) << bus.req_size_i;
        w_beats       = c_W'(bus.req_len_i) + c_W'(1);
        // Ceiling division: an unaligned first beat still costs a full beat.
        w_room        = (c_BOUND - w_off + w_bpb - c_W'(1)) >> bus.req_size_i;
        w_total       = w_beats << bus.req_size_i;
        w_wrap_off    = w_off & ~(w_total - c_W'(1));
        w_size_ok     = (bus.req_size_i <= 3'(DATA_LOG2));
        w_aligned     = ((w_off & (w_bpb - c_W'(1))) == '0);
        w_len_wrap_ok = (bus.req_len_i inside {8'd1, 8'd3, 8'd7, 8'd15});

        w_legal = 1'b0;
        w_split = 1'b0;
        if (w_size_ok) begin
            case (bus.req_burst_i)
                c_BURST_FIXED: w_legal = ((w_off + w_bpb) <= c_BOUND);
                c_BURST_WRAP:  w_legal = w_len_wrap_ok && w_aligned &&
                                         ((w_wrap_off + w_total) <= c_BOUND);
                c_BURST_INCR: begin
                    if (w_beats <= w_room) begin
                        w_legal = 1'b1;
                    end else if (SPLIT_EN) begin
                        w_split = 1'b1;
                    end
                end
                default: ;  // reserved encoding
            endcase
        end
        w_violation = !(w_legal || w_split);
    end

    // ------------------------------------------------------------------
    // Continuation sub-burst sizing: a full region holds 2^(BOUND-size) beats
    // ------------------------------------------------------------------
    logic [c_W-1:0] w_max;
    logic [c_W-1:0] w_rem;
    logic [c_W-1:0] w_chunk;

    always_comb begin
        w_max   = c_BOUND >> r_out_size;
        w_rem   = c_W'(r_rem);
        w_chunk = (w_rem < w_max) ? w_rem : w_max;
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_out_addr_nxt  = r_out_addr;
        w_out_len_nxt   = r_out_len;
        w_out_size_nxt  = r_out_size;
        w_out_burst_nxt = r_out_burst;
        w_out_id_nxt    = r_out_id;
        w_out_last_nxt  = r_out_last;
        w_rem_nxt       = r_rem;
        w_next_addr_nxt = r_next_addr;
        w_viol_nxt      = 1'b0;
        w_viol_id_nxt   = r_viol_id;

        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    if (w_violation) begin
                        w_viol_nxt    = 1'b1;
                        w_viol_id_nxt = bus.req_id_i;
                    end else begin
                        w_state_nxt     = ST_ISSUE;
                        w_out_addr_nxt  = bus.req_addr_i;
                        w_out_size_nxt  = bus.req_size_i;
                        w_out_burst_nxt = bus.req_burst_i;
                        w_out_id_nxt    = bus.req_id_i;
                        if (w_split) begin
                            w_out_len_nxt   = 8'(w_room - c_W'(1));
                            w_out_last_nxt  = 1'b0;
                            w_rem_nxt       = 9'(w_beats - w_room);
                            w_next_addr_nxt = (bus.req_addr_i & ~c_OFF_MASK) + c_BOUND_A;
                        end else begin
                            w_out_len_nxt   = bus.req_len_i;
                            w_out_last_nxt  = 1'b1;
                            w_rem_nxt       = 9'd0;
                        end
                    end
                end
            end

            ST_ISSUE: begin
                if (bus.out_ready_i) begin
                    if (r_out_last) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_out_addr_nxt  = r_next_addr;
                        w_out_len_nxt   = 8'(w_chunk - c_W'(1));
                        w_out_last_nxt  = (w_rem <= w_max);
                        w_rem_nxt       = r_rem - 9'(w_chunk);
                        w_next_addr_nxt = r_next_addr + c_BOUND_A;
                    end
                end
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_out_addr  <= '0;
            r_out_len   <= '0;
            r_out_size  <= '0;
            r_out_burst <= '0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
            r_rem       <= '0;
            r_next_addr <= '0;
            r_viol      <= 1'b0;
            r_viol_id   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_addr  <= w_out_addr_nxt;
            r_out_len   <= w_out_len_nxt;
            r_out_size  <= w_out_size_nxt;
            r_out_burst <= w_out_burst_nxt;
            r_out_id    <= w_out_id_nxt;
            r_out_last  <= w_out_last_nxt;
            r_rem       <= w_rem_nxt;
            r_next_addr <= w_next_addr_nxt;
            r_viol      <= w_viol_nxt;
            r_viol_id   <= w_viol_id_nxt;
        end
    end

    // All outputs come straight from registers.
    assign bus.req_ready_o          = (r_state == ST_IDLE);
    assign bus.out_valid_o          = (r_state == ST_ISSUE);
    assign bus.out_addr_o           = r_out_addr;
    assign bus.out_len_o            = r_out_len;
    assign bus.out_size_o           = r_out_size;
    assign bus.out_burst_o          = r_out_burst;
    assign bus.out_id_o             = r_out_id;
    assign bus.out_last_o           = r_out_last;
    assign bus.bound_violation_o    = r_viol;
    assign bus.bound_violation_id_o = r_viol_id;

endmodule
`default_nettype wire

// File: tb/tb_rv_iommu_axi4_burst_splitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_iommu_axi4_burst_splitter
// Description : Scoreboard bench for rv_iommu_axi4_burst_splitter. Two
//               instances: one with splitting enabled, one with splitting
//               disabled. Expected sub-bursts are derived by walking each
//               beat's byte address and grouping beats by boundary region.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_iommu_axi4_burst_splitter;

    localparam int AW = 64;
    localparam int IW = 4;
    localparam int BL = 12;
    localparam int DL = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [IW-1:0] id;
        logic          last;
    } sub_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rdy_mode = 0;   // 0 random, 1 held low, 2 held high

    sub_t          exp_s[$];
    sub_t          exp_n[$];
    logic [IW-1:0] vexp_s[$];
    logic [IW-1:0] vexp_n[$];

    always #5 clk = ~clk;

    rv_iommu_axi4_burst_splitter_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus_s ();
    rv_iommu_axi4_burst_splitter_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) bus_n ();

    rv_iommu_axi4_burst_splitter #(
        .ADDR_WIDTH(AW), .BOUND_LOG2(BL), .DATA_LOG2(DL), .ID_WIDTH(IW), .SPLIT_EN(1'b1)
    ) dut_s (.clk_i(clk), .rst_i(rst), .bus(bus_s));

    rv_iommu_axi4_burst_splitter #(
        .ADDR_WIDTH(AW), .BOUND_LOG2(BL), .DATA_LOG2(DL), .ID_WIDTH(IW), .SPLIT_EN(1'b0)
    ) dut_n (.clk_i(clk), .rst_i(rst), .bus(bus_n));

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic void model_push(input bit which, input logic [63:0] a,
                                       input logic [1:0] bu, input logic [7:0] ln,
                                       input logic [2:0] sz, input logic [IW-1:0] id);
        logic [63:0] bytes, total, wb, al, ba;
        logic [63:0] starts[$];
        int          counts[$];
        int          beats;
        int          idx;
        bit          ok;
        sub_t        s;
        bytes = 64'd1 << sz;
        beats = int'(ln) + 1;
        ok    = 1'b0;
        if (sz <= 3'(DL) && bu != 2'b11) begin
            if (bu == 2'b01) begin
                al = a - (a % bytes);
                for (int i = 0; i < beats; i++) begin
                    ba = (i == 0) ? a : al + 64'(i) * bytes;
                    if (i == 0) begin
                        starts.push_back(ba);
                        counts.push_back(1);
                    end else if ((ba >> BL) != (starts[starts.size()-1] >> BL)) begin
                        starts.push_back(ba);
                        counts.push_back(1);
                    end else begin
                        idx = counts.size() - 1;
                        counts[idx] = counts[idx] + 1;
                    end
                end
                ok = (starts.size() == 1) || (which == 1'b0);
            end else begin
                if (bu == 2'b00) begin
                    ok = (((a + bytes - 64'd1) >> BL) == (a >> BL));
                end else begin
                    total = 64'(beats) * bytes;
                    wb    = a - (a % total);
                    ok    = (ln inside {8'd1, 8'd3, 8'd7, 8'd15}) && ((a % bytes) == 64'd0) &&
                            ((wb >> BL) == ((wb + total - 64'd1) >> BL));
                end
                starts.push_back(a);
                counts.push_back(beats);
            end
        end
        if (!ok) begin
            if (which) vexp_n.push_back(id); else vexp_s.push_back(id);
        end else begin
            for (int g = 0; g < starts.size(); g++) begin
                s = {starts[g], 8'(counts[g] - 1), sz, bu, id, (g == starts.size() - 1)};
                if (which) exp_n.push_back(s); else exp_s.push_back(s);
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endfunction

    function automatic void check_sub(input bit which, input sub_t got);
        sub_t e;
        bit   have;
        have = 1'b0;
        n_checks++;
        if (which && exp_n.size() != 0) begin e = exp_n.pop_front(); have = 1'b1; end
        if (!which && exp_s.size() != 0) begin e = exp_s.pop_front(); have = 1'b1; end
        if (!have) begin
            n_fail++;
            $display("FAIL sub%0d_unexpected: got addr=%h len=%0d last=%0d, required no output",
                     which, got.addr, got.len, got.last);
        end else if (got !== e) begin
            n_fail++;
            $display("FAIL sub%0d: got addr=%h len=%0d size=%0d burst=%0d id=%0d last=%0d required addr=%h len=%0d size=%0d burst=%0d id=%0d last=%0d",
                     which, got.addr, got.len, got.size, got.burst, got.id, got.last,
                     e.addr, e.len, e.size, e.burst, e.id, e.last);
        end
    endfunction

    function automatic void check_viol(input bit which, input logic [IW-1:0] got);
        logic [IW-1:0] e;
        bit            have;
        have = 1'b0;
        n_checks++;
        if (which && vexp_n.size() != 0) begin e = vexp_n.pop_front(); have = 1'b1; end
        if (!which && vexp_s.size() != 0) begin e = vexp_s.pop_front(); have = 1'b1; end
        if (!have) begin
            n_fail++;
            $display("FAIL viol%0d_unexpected: got pulse id=%0d, required none", which, got);
        end else if (got !== e) begin
            n_fail++;
            $display("FAIL viol%0d_id: got %0d required %0d", which, got, e);
        end
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit   prev_hold = 1'b0;
    sub_t prev_sub;

    initial begin
        sub_t cur_s, cur_n;
        forever begin
            @(negedge clk);
            cur_s = {bus_s.out_addr_o, bus_s.out_len_o, bus_s.out_size_o, bus_s.out_burst_o,
                     bus_s.out_id_o, bus_s.out_last_o};
            cur_n = {bus_n.out_addr_o, bus_n.out_len_o, bus_n.out_size_o, bus_n.out_burst_o,
                     bus_n.out_id_o, bus_n.out_last_o};
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    n_checks++;
                    if (!bus_s.out_valid_o || cur_s !== prev_sub) begin
                        n_fail++;
                        $display("FAIL stability: got valid=%0d addr=%h len=%0d required valid=1 addr=%h len=%0d",
                                 bus_s.out_valid_o, cur_s.addr, cur_s.len, prev_sub.addr, prev_sub.len);
                    end
                end
                if (bus_s.out_valid_o && bus_s.out_ready_i) check_sub(1'b0, cur_s);
                if (bus_n.out_valid_o && bus_n.out_ready_i) check_sub(1'b1, cur_n);
                if (bus_s.bound_violation_o) check_viol(1'b0, bus_s.bound_violation_id_o);
                if (bus_n.bound_violation_o) check_viol(1'b1, bus_n.bound_violation_id_o);
                prev_hold = bus_s.out_valid_o && !bus_s.out_ready_i;
                prev_sub  = cur_s;
            end
        end
    end

    // out_ready driver for the splitting instance
    initial begin
        bus_s.out_ready_i = 1'b0;
        bus_n.out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       bus_s.out_ready_i = 1'b0;
                2:       bus_s.out_ready_i = 1'b1;
                default: bus_s.out_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic drive(input bit which, input logic v, input logic [63:0] a, input logic [1:0] bu,
                         input logic [7:0] ln, input logic [2:0] sz, input logic [IW-1:0] id);
        if (which) begin
            bus_n.req_valid_i = v; bus_n.req_addr_i = a; bus_n.req_burst_i = bu;
            bus_n.req_len_i = ln; bus_n.req_size_i = sz; bus_n.req_id_i = id;
        end else begin
            bus_s.req_valid_i = v; bus_s.req_addr_i = a; bus_s.req_burst_i = bu;
            bus_s.req_len_i = ln; bus_s.req_size_i = sz; bus_s.req_id_i = id;
        end
    endtask

    function automatic logic ready_of(input bit which);
        return which ? bus_n.req_ready_o : bus_s.req_ready_o;
    endfunction

    task automatic send(input bit which, input logic [63:0] a, input logic [1:0] bu,
                        input logic [7:0] ln, input logic [2:0] sz, input logic [IW-1:0] id);
        int guard;
        guard = 0;
        @(posedge clk);
        #1;
        drive(which, 1'b1, a, bu, ln, sz, id);
        @(negedge clk);
        while (!ready_of(which) && guard < 2000) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready_o=0 for %0d cycles, required 1", guard);
            drive(which, 1'b0, a, bu, ln, sz, id);
            return;
        end
        @(posedge clk);
        #1;
        drive(which, 1'b0, a, bu, ln, sz, id);
        model_push(which, a, bu, ln, sz, id);
    endtask

    task automatic send_rand(input bit which);
        logic [63:0] a;
        logic [7:0]  ln;
        logic [2:0]  sz;
        logic [1:0]  bu;
        a  = {$urandom, $urandom};
        bu = 2'($urandom_range(0, 3));
        sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFFF - 12'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << sz) - 64'd1);
        case ($urandom_range(0, 2))
            0:       ln = 8'($urandom_range(0, 255));
            1:       ln = 8'($urandom_range(0, 16));
            default: ln = 8'((1 << $urandom_range(0, 4)) - 1);
        endcase
        send(which, a, bu, ln, sz, 4'($urandom_range(0, 15)));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_s.size() + exp_n.size() + vexp_s.size() + vexp_n.size()) != 0 && guard < 3000) begin
            guard++;
            @(negedge clk);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive(1'b0, 1'b0, 64'd0, 2'd0, 8'd0, 3'd0, 4'd0);
        drive(1'b1, 1'b0, 64'd0, 2'd0, 8'd0, 3'd0, 4'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_req_ready",  64'(bus_s.req_ready_o), 64'd1);
        chk("rst_out_valid",  64'(bus_s.out_valid_o), 64'd0);
        chk("rst_violation",  64'(bus_s.bound_violation_o), 64'd0);
        chk("rst_out_addr",   bus_s.out_addr_o, 64'd0);
        chk("rst_out_len",    64'(bus_s.out_len_o), 64'd0);
        chk("rst_out_last",   64'(bus_s.out_last_o), 64'd0);
        chk("rst_viol_id",    64'(bus_s.bound_violation_id_o), 64'd0);
        chk("rst_n_req_ready", 64'(bus_n.req_ready_o), 64'd1);
        chk("rst_n_out_valid", 64'(bus_n.out_valid_o), 64'd0);

        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed cases on the splitting instance
        send(1'b0, 64'h1000, 2'b01, 8'd15, 3'd3, 4'd1);
        send(1'b0, 64'h1FC0, 2'b01, 8'd15, 3'd3, 4'd2);
        send(1'b0, 64'h1FF0, 2'b10, 8'd3,  3'd3, 4'd3);
        send(1'b0, 64'h1FF0, 2'b10, 8'd2,  3'd3, 4'd4);
        send(1'b0, 64'h0FFC, 2'b00, 8'd0,  3'd3, 4'd5);
        send(1'b0, 64'h0FF8, 2'b00, 8'd0,  3'd3, 4'd6);
        send(1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 2'b01, 8'd15, 3'd3, 4'd7);
        send(1'b0, 64'h0FFD, 2'b01, 8'd1,  3'd3, 4'd8);
        send(1'b0, 64'h0000, 2'b11, 8'd0,  3'd0, 4'd9);
        send(1'b0, 64'h0000, 2'b01, 8'd0,  3'd4, 4'd10);
        // Directed cases on the non-splitting instance
        send(1'b1, 64'h1FC0, 2'b01, 8'd15, 3'd3, 4'd11);
        send(1'b1, 64'h1000, 2'b01, 8'd15, 3'd3, 4'd12);
        drain();

        for (int i = 0; i < 300; i++) send_rand(1'b0);
        for (int i = 0; i < 80; i++)  send_rand(1'b1);
        drain();

        // Stall with a split in progress
        rdy_mode = 1;
        @(posedge clk);
        send(1'b0, 64'h1FC0, 2'b01, 8'd15, 3'd3, 4'd13);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid",     64'(bus_s.out_valid_o), 64'd1);
            chk("stall_addr",      bus_s.out_addr_o, 64'h1FC0);
            chk("stall_len",       64'(bus_s.out_len_o), 64'd7);
            chk("stall_last",      64'(bus_s.out_last_o), 64'd0);
            chk("stall_req_ready", 64'(bus_s.req_ready_o), 64'd0);
        end
        rdy_mode = 2;
        drain();

        // Asynchronous reset in the middle of a split
        rdy_mode = 1;
        @(posedge clk);
        send(1'b0, 64'h3F80, 2'b01, 8'd31, 3'd3, 4'd14);
        @(negedge clk);
        chk("pre_rst_valid", 64'(bus_s.out_valid_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid",     64'(bus_s.out_valid_o), 64'd0);
        chk("async_rst_req_ready", 64'(bus_s.req_ready_o), 64'd1);
        chk("async_rst_addr",      bus_s.out_addr_o, 64'd0);
        exp_s.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0;

        for (int i = 0; i < 100; i++) send_rand(1'b0);
        drain();

        chk("final_exp_s_empty",  64'(exp_s.size()), 64'd0);
        chk("final_exp_n_empty",  64'(exp_n.size()), 64'd0);
        chk("final_vexp_s_empty", 64'(vexp_s.size()), 64'd0);
        chk("final_vexp_n_empty", 64'(vexp_n.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
